mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/mix_single_column.sv | 46 ++++
 rtl/mix_columns_seq.sv | 170 +++++++++++++++++
 tb/tb_mix_columns_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES column-mixing definitions: GF(2^8) constant multipliers and the
// control FSM encoding used by mix_columns_seq.
package aes_pkg;

    localparam logic [7:0] AES_RED = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RED : 8'h00);
    endfunction

    function automatic logic [7:0] x2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] x3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] x9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] xb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] xd(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] xe(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns of one 32-bit column, row 0 in the MSB byte.
// The inverse path exists only when MIX_COLUMNS_INV_EN is defined.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] b0_s, b1_s, b2_s, b3_s;

    assign b0_s = col_in[31:24];
    assign b1_s = col_in[23:16];
    assign b2_s = col_in[15:8];
    assign b3_s = col_in[7:0];

`ifdef MIX_COLUMNS_INV_EN
    // Matrix product selected by the registered mode bit
    always_comb begin
        if (inv) begin
            col_out = {xe(b0_s) ^ xb(b1_s) ^ xd(b2_s) ^ x9(b3_s),
                       x9(b0_s) ^ xe(b1_s) ^ xb(b2_s) ^ xd(b3_s),
                       xd(b0_s) ^ x9(b1_s) ^ xe(b2_s) ^ xb(b3_s),
                       xb(b0_s) ^ xd(b1_s) ^ x9(b2_s) ^ xe(b3_s)};
        end else begin
            col_out = {x2(b0_s) ^ x3(b1_s) ^ b2_s ^ b3_s,
                       b0_s ^ x2(b1_s) ^ x3(b2_s) ^ b3_s,
                       b0_s ^ b1_s ^ x2(b2_s) ^ x3(b3_s),
                       x3(b0_s) ^ b1_s ^ b2_s ^ x2(b3_s)};
        end
    end
`else
    logic unused_inv_s;
    assign unused_inv_s = inv;

    // Forward-only matrix product
    always_comb begin
        col_out = {x2(b0_s) ^ x3(b1_s) ^ b2_s ^ b3_s,
                   b0_s ^ x2(b1_s) ^ x3(b2_s) ^ b3_s,
                   b0_s ^ b1_s ^ x2(b2_s) ^ x3(b3_s),
                   x3(b0_s) ^ b1_s ^ b2_s ^ x2(b3_s)};
    end
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Define MIX_COLUMNS_INV_EN to build InvMixColumns selectable by in_inv.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [2:0] COL_STEP = 3'(COLS_PER_CYCLE);

    mc_state_e    state_q, state_d;
    logic [2:0]   col_q, col_d, col_sum_s;
    logic [127:0] data_q, data_d, shift_s;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         rdy_q, inv_q;
    logic         accept_s, last_s, in_ready_s, busy_s;
    logic [31:0]  col_out_s [COLS_PER_CYCLE];

    // The working state shifts left each cycle, so the next columns are always on top
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        mix_single_column u_col (
            .col_in  (data_q[127-32*g -: 32]),
            .inv     (inv_q),
            .col_out (col_out_s[g])
        );
    end

    assign col_sum_s = col_q + COL_STEP;
    assign last_s    = (state_q == ST_BUSY) && (col_sum_s == 3'd4);
    assign accept_s  = in_valid && in_ready_s;

    // Shift processed columns out of the top and append results at the bottom
    always_comb begin
        shift_s = data_q << (32 * COLS_PER_CYCLE);
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            shift_s[32*(COLS_PER_CYCLE-1-k) +: 32] = col_out_s[k];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_BUSY;
                else          state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_s) state_d = ST_DONE;
                else        state_d = ST_BUSY;
            end
            ST_DONE: begin
                if (accept_s)       state_d = ST_BUSY;
                else if (out_ready) state_d = ST_IDLE;
                else                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; rdy_q keeps in_ready low until the first edge out of reset
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = rdy_q;
                busy_s     = 1'b0;
            end
            ST_BUSY: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                in_ready_s = rdy_q && out_ready;
                busy_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Datapath next values: capture, column processing, result publication
    always_comb begin
        data_d = data_q;
        col_d  = col_q;
        if (accept_s) begin
            data_d = in_data;
            col_d  = 3'd0;
        end else if (state_q == ST_BUSY) begin
            data_d = shift_s;
            col_d  = last_s ? 3'd0 : col_sum_s;
        end else begin
            data_d = data_q;
            col_d  = col_q;
        end
        if (last_s) out_data_d = shift_s;
        else        out_data_d = out_data_q;
        out_valid_d = (state_d == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= 128'h0;
            col_q       <= 3'd0;
            out_data_q  <= 128'h0;
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            col_q       <= col_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rdy_q       <= 1'b1;
        end
    end

`ifdef MIX_COLUMNS_INV_EN
    logic inv_d;

    // Mode is latched at acceptance and held for the whole state
    always_comb begin
        if (accept_s) inv_d = in_inv;
        else          inv_d = inv_q;
    end

    // Mode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`else
    logic unused_in_inv_s;
    assign unused_in_inv_s = in_inv;
    assign inv_q           = 1'b0;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_s;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: GF(2^8) matrix reference model,
// per-cycle scoreboard, directed vectors and randomized traffic.
module tb_mix_columns_seq;

    localparam int C1   = 1;
    localparam int LAT1 = 4 / C1 + 1;
    localparam logic [127:0] VEC_A = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] VEC_B = 128'h046681e5e0cb199a48f8d37a2806264c;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, busy4;
    logic [127:0] in_data4, out_data4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [31:0] cv_in  [4] = '{32'hdb135345, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
    logic [31:0] cv_out [4] = '{32'h8e4da1bc, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};

    mix_columns_seq #(.COLS_PER_CYCLE(C1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_inv(in_inv4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Circulant matrix times each column of the state
    function automatic logic [127:0] gf_mix(input logic [127:0] s, input bit inv);
        logic [7:0] coef [4];
        logic [7:0] b [4];
        logic [7:0] r;
        logic [127:0] o;
        o = '0;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) b[j] = s[127-32*c-8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(b[j], coef[(j - row + 4) % 4]);
                o[127-32*c-8*row -: 8] = r;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] model_expect(input logic [127:0] s, input bit inv);
`ifdef MIX_COLUMNS_INV_EN
        return gf_mix(s, inv);
`else
        return gf_mix(s, 1'b0);
`endif
    endfunction

    typedef struct {
        logic [127:0] d;
        int           acc;
    } item_t;

    item_t        sb_q[$];
    bit           hold_prev = 1'b0;
    logic [127:0] prev_data = '0;
    bit           model_done, exp_ready;

    // Scoreboard: the model knows when a result is due from its acceptance cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            check(out_valid == 1'b0 && out_data == 128'h0 && busy == 1'b0 && in_ready == 1'b0,
                  "reset_outputs", {out_valid, busy, in_ready, out_data[124:0]}, 128'h0);
            sb_q.delete();
            hold_prev = 1'b0;
        end else begin
            model_done = (sb_q.size() != 0) && (cyc - sb_q[0].acc >= LAT1);
            exp_ready  = (sb_q.size() == 0) || (model_done && out_ready);
            check(out_valid == model_done, "mon_out_valid", 128'(out_valid), 128'(model_done));
            check(busy == (sb_q.size() != 0), "mon_busy", 128'(busy), 128'(sb_q.size() != 0));
            check(in_ready == exp_ready, "mon_in_ready", 128'(in_ready), 128'(exp_ready));
            if (model_done) check(out_data == sb_q[0].d, "mon_out_data", out_data, sb_q[0].d);
            if (hold_prev) check(out_data == prev_data, "mon_hold_stable", out_data, prev_data);
            hold_prev = model_done && !out_ready;
            prev_data = out_data;
            if (model_done && out_ready) void'(sb_q.pop_front());
            if (in_valid && exp_ready) sb_q.push_back('{model_expect(in_data, in_inv), cyc});
        end
    end

    task automatic send(input logic [127:0] d, input logic inv);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_inv = inv;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        acc_cyc = cyc;
        check(got, "send_accept_timeout", 128'(got), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [127:0] d, output int lat);
        d = '0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin d = out_data; lat = cyc - acc_cyc; break; end
        end
        check(lat >= 0, "wait_out_timeout", 128'(lat), 128'(LAT1));
    endtask

    task automatic run_vec(input logic [127:0] d, input logic inv, input logic [127:0] exp, input string name);
        logic [127:0] r;
        int lat;
        send(d, inv);
        wait_out(r, lat);
        check(r == exp, name, r, exp);
    endtask

    task automatic run4(input logic [127:0] d, input logic inv, input logic [127:0] exp, input string name);
        int lat;
        bit got;
        got = 1'b0;
        lat = -1;
        @(posedge clk); #1;
        in_valid4 = 1'b1; in_data4 = d; in_inv4 = inv;
        @(negedge clk);
        got = in_ready4;
        check(got, "c4_in_ready", 128'(got), 128'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid4) begin lat = cyc - acc_cyc; break; end
        end
        check(lat == 2, "c4_latency", 128'(lat), 128'd2);
        check(out_data4 == exp, name, out_data4, exp);
    endtask

    initial begin
        logic [127:0] r, r0;
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; in_inv4 = 1'b0; out_ready4 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1 check(in_ready == 1'b0, "ready_before_first_edge", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        check(in_ready == 1'b1, "ready_after_first_edge", 128'(in_ready), 128'd1);

        // Pin the reference model to known vectors
        check(gf_mix(VEC_A, 1'b0) == VEC_B, "model_fwd", gf_mix(VEC_A, 1'b0), VEC_B);
        check(gf_mix(VEC_B, 1'b1) == VEC_A, "model_inv", gf_mix(VEC_B, 1'b1), VEC_A);
        for (int i = 0; i < 4; i++) begin
            check(gf_mix({4{cv_in[i]}}, 1'b0) == {4{cv_out[i]}}, "model_col_fwd",
                  gf_mix({4{cv_in[i]}}, 1'b0), {4{cv_out[i]}});
            check(gf_mix({4{cv_out[i]}}, 1'b1) == {4{cv_in[i]}}, "model_col_inv",
                  gf_mix({4{cv_out[i]}}, 1'b1), {4{cv_in[i]}});
        end

        // Forward vector with latency
        send(VEC_A, 1'b0);
        wait_out(r, lat);
        check(r == VEC_B, "fwd_vector", r, VEC_B);
        check(lat == 5, "fwd_latency", 128'(lat), 128'd5);

        for (int i = 0; i < 4; i++) begin
            run_vec({4{cv_in[i]}}, 1'b0, {4{cv_out[i]}}, "col_fwd");
`ifdef MIX_COLUMNS_INV_EN
            run_vec({4{cv_out[i]}}, 1'b1, {4{cv_in[i]}}, "col_inv");
`else
            run_vec({4{cv_out[i]}}, 1'b1, gf_mix({4{cv_out[i]}}, 1'b0), "col_inv_ignored");
`endif
        end

`ifdef MIX_COLUMNS_INV_EN
        run_vec(VEC_A, 1'b1, gf_mix(VEC_A, 1'b1), "inv_mode_selected");
        run4(VEC_B, 1'b1, VEC_A, "c4_inverse");
`else
        run_vec(VEC_A, 1'b1, VEC_B, "inv_disabled_fwd");
        run4(VEC_B, 1'b1, gf_mix(VEC_B, 1'b0), "c4_inv_disabled");
`endif
        run4(VEC_A, 1'b0, VEC_B, "c4_forward");

        // Backpressure: hold, then simultaneous handshake and acceptance
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(VEC_A, 1'b0);
        wait_out(r0, lat);
        check(r0 == VEC_B, "bp_result", r0, VEC_B);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(out_valid && out_data == r0 && !in_ready, "bp_hold",
                  {out_valid, in_ready, out_data[125:0]}, {1'b1, 1'b0, r0[125:0]});
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = {4{cv_in[0]}}; in_inv = 1'b0;
        @(negedge clk);
        check(in_ready == 1'b1, "bp_same_cycle_accept", 128'(in_ready), 128'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check(busy && !out_valid, "bp_no_bubble", {busy, out_valid}, 128'h2);
        wait_out(r, lat);
        check(r == {4{cv_out[0]}}, "bp_next_result", r, {4{cv_out[0]}});
        check(lat == 5, "bp_next_latency", 128'(lat), 128'd5);

        // Reset mid-BUSY with the column counter at 2
        send(VEC_B, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check(out_valid == 1'b0 && out_data == 128'h0 && busy == 1'b0 && in_ready == 1'b0,
                 "reset_mid_busy", {out_valid, busy, in_ready, out_data[124:0]}, 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check(out_valid == 1'b0, "no_spurious_after_reset", 128'(out_valid), 128'd0);
        end

        // Randomized traffic, checked by the scoreboard every cycle
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_inv    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check(sb_q.size() == 0, "drain_empty", 128'(sb_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
